mult_share_arbiter: RTL

//  Round-robin, burst-locking arbiter sharing one external multiplier (DSP slice or mutArrayS) between
//  NUM_REQ filter engines (e.g. several MAVG/FIR channels built with *_USE_EXT_MULT).

---
 rtl/mult_share_arbiter_if.sv | 33 +++
 rtl/mult_share_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_if.sv
// Bundle between the filter channels, the shared multiplier and mult_share_arbiter.
// The slave modport is the arbiter side; the master modport is the channels/multiplier side.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int BITWIDTH_A = 16,
  parameter int BITWIDTH_B = 16
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = BITWIDTH_A + BITWIDTH_B;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*BITWIDTH_A-1:0] ina_bus;
  logic [NUM_REQ*BITWIDTH_B-1:0] inb_bus;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            preempt;
  logic [OW-1:0]                 owner;
  logic                          busy;
  logic [BITWIDTH_A-1:0]         mult_ina;
  logic [BITWIDTH_B-1:0]         mult_inb;
  logic [PW-1:0]                 mult_out;
  logic [PW-1:0]                 prod_out;
  logic [NUM_REQ-1:0]            prod_valid;

  modport slave (
    input  req, ina_bus, inb_bus, mult_out,
    output gnt, preempt, owner, busy, mult_ina, mult_inb, prod_out, prod_valid
  );

  modport master (
    output req, ina_bus, inb_bus, mult_out,
    input  gnt, preempt, owner, busy, mult_ina, mult_inb, prod_out, prod_valid
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin, burst-locking arbiter for one shared multiplier among NUM_REQ channels.
// Optional macro MULT_SHARE_OUTREG_EN registers the product and its valid one extra cycle.
module mult_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BITWIDTH_A = 16,
  parameter int BITWIDTH_B = 16,
  parameter int MAX_BURST  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  mult_share_arbiter_if.slave  bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 2);
  localparam int PW = BITWIDTH_A + BITWIDTH_B;

  localparam logic [0:0]    S_IDLE  = 1'b0;
  localparam logic [0:0]    S_GRANT = 1'b1;
  localparam logic [CW-1:0] C_LAST  = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [OW-1:0] OWN_RST = OW'(NUM_REQ - 1);

  logic [0:0]            r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_preempt;
  logic [OW-1:0]         r_owner;
  logic [CW-1:0]         r_cnt;

  logic                  w_clr;
  logic [OW-1:0]         w_pick;
  logic                  w_found;
  logic                  w_own_req;
  logic                  w_others;
  logic                  w_cut;
  logic [BITWIDTH_A-1:0] w_ina;
  logic [BITWIDTH_B-1:0] w_inb;

  assign w_clr     = i_rst | ~i_en;
  assign w_own_req = bus.req[r_owner];
  // While granted, r_gnt is the owner's one-hot, so masking it leaves only competitors.
  assign w_others  = |(bus.req & ~r_gnt);
  assign w_cut     = (MAX_BURST != 0) && (r_cnt == C_LAST) && w_others;

  // Search starts just after the last owner, so a preempted channel waits for everyone else.
  always_comb begin
    w_pick  = r_owner;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!w_found && bus.req[(int'(r_owner) + i) % NUM_REQ]) begin
        w_found = 1'b1;
        w_pick  = OW'((int'(r_owner) + i) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_preempt <= '0;
      r_owner   <= OWN_RST;
      r_cnt     <= '0;
    end else begin
      r_preempt <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_GRANT;
            r_gnt   <= NUM_REQ'(1) << w_pick;
            r_owner <= w_pick;
            r_cnt   <= '0;
          end
        end
        default: begin
          // Release wins over preemption when both happen together.
          if (!w_own_req) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
          end else if (w_cut) begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_preempt <= r_gnt;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Operands are forced to zero when nobody owns the multiplier to keep it quiet.
  always_comb begin
    w_ina = '0;
    w_inb = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_gnt[k]) begin
        w_ina = w_ina | bus.ina_bus[k*BITWIDTH_A +: BITWIDTH_A];
        w_inb = w_inb | bus.inb_bus[k*BITWIDTH_B +: BITWIDTH_B];
      end
    end
  end

  assign bus.gnt      = r_gnt;
  assign bus.preempt  = r_preempt;
  assign bus.owner    = r_owner;
  assign bus.busy     = |r_gnt;
  assign bus.mult_ina = w_ina;
  assign bus.mult_inb = w_inb;

`ifdef MULT_SHARE_OUTREG_EN
  logic [PW-1:0]      r_prod;
  logic [NUM_REQ-1:0] r_pvld;

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_prod <= '0;
      r_pvld <= '0;
    end else begin
      r_prod <= bus.mult_out;
      r_pvld <= r_gnt;
    end
  end

  assign bus.prod_out   = r_prod;
  assign bus.prod_valid = r_pvld;
`else
  assign bus.prod_out   = PW'(bus.mult_out);
  assign bus.prod_valid = r_gnt;
`endif
endmodule
